// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources compete for the register-file write port:
// wb0 is the execute stage and wb1 is the memory (load) stage.
// After reset, the block can optionally clear x1..x31 before it
// starts arbitrating.
//
// Handshake:
//   A transfer happens on a cycle where valid && ready are both high.
//   ready is a combinational function of both valids and the
//   round-robin flop, and at most one ready is high per cycle.
//   A source that loses arbitration may drop its valid; the arbiter
//   keeps no memory of the request.
//
// Write timing:
//   The accepted address and data reach waddr/wdata/reg_wr on the
//   following posedge.
//   A transfer to x0 is accepted but produces no write.
module regfile_wb_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb0_valid,
  input  logic [4:0]             wb0_addr,
  input  logic [31:0]            wb0_data,
  output logic                   wb0_ready,
  input  logic                   wb1_valid,
  input  logic [4:0]             wb1_addr,
  input  logic [31:0]            wb1_data,
  output logic                   wb1_ready,
  output logic                   reg_wr,
  output logic [4:0]             waddr,
  output logic [31:0]            wdata,
  output logic                   init_done,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   dbg_state
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE   = CLEAR_ON_RESET ? S_INIT : S_RUN;
  localparam logic   INIT_DONE_RST = ~CLEAR_ON_RESET;

  state_t                   state;
  logic [4:0]               clr_cnt;
  logic                     last_grant;   // 1 = wb1 was granted last
  logic                     run;
  logic                     gnt0;
  logic                     gnt1;
  logic                     stall;

  // Round-robin grant.
  // reset is folded in so that the readies stay low while reset is held.
  always_comb begin
    run   = (state == S_RUN) && reset;
    gnt0  = run && wb0_valid && (!wb1_valid || last_grant);
    gnt1  = run && wb1_valid && (!wb0_valid || !last_grant);
    stall = run && ((wb0_valid && !gnt0) || (wb1_valid && !gnt1));
  end

  assign wb0_ready = gnt0;
  assign wb1_ready = gnt1;
  assign dbg_state = (state == S_RUN);

  // Clear sequencer, write-port register, round-robin flop and stall counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      clr_cnt    <= 5'd1;
      last_grant <= 1'b1;
      reg_wr     <= 1'b0;
      waddr      <= 5'd0;
      wdata      <= 32'd0;
      init_done  <= INIT_DONE_RST;
      stall_cnt  <= '0;
    end else begin
      case (state)
        S_INIT: begin
          reg_wr  <= 1'b1;
          waddr   <= clr_cnt;
          wdata   <= 32'd0;
          clr_cnt <= clr_cnt + 5'd1;
          if (clr_cnt == 5'd31) state <= S_RUN;
        end
        S_RUN: begin
          init_done <= 1'b1;
          if (gnt0) begin
            last_grant <= 1'b0;
            reg_wr     <= (wb0_addr != 5'd0);
            if (wb0_addr != 5'd0) begin
              waddr <= wb0_addr;
              wdata <= wb0_data;
            end
          end else if (gnt1) begin
            last_grant <= 1'b1;
            reg_wr     <= (wb1_addr != 5'd0);
            if (wb1_addr != 5'd0) begin
              waddr <= wb1_addr;
              wdata <= wb1_data;
            end
          end else begin
            reg_wr <= 1'b0;
          end
          if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule
